mysystem_done_signal_in: RTL and testbench
==========================================

# mysystem_done_signal_in

Avalon-MM slave input port that returns the "done" status of an accelerator to the Nios II host. It is the readback counterpart of the host's start-signal output port. It synchronizes an asynchronous input bus, latches selected edges into sticky capture bits, and raises a maskable interrupt. It sits on the system interconnect beside the start-signal port, with `in_port` wired to the accelerator's done/status lines.

## Interface
- `DATA_WIDTH`, 1 — width of `in_port`, capture and mask registers (1..32).
- `EDGE_TYPE`, 0 — capture edge: 0 rising, 1 falling, 2 any.
- `RESET_VALUE`, 0 — value loaded into the synchronizer/history flops at reset.

- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  3  word address of the register.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data, fixed read latency 1.
- `in_port`  in  DATA_WIDTH  asynchronous done/status inputs.
- `irq`  out  1  level interrupt to the host.

## Operation
- Register map. Unused bits read 0. Addresses 1, 6 and 7 read 0 and ignore writes.
  - 0 DATA (RO): synchronized `in_port`. Writes are ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAPTURE (R/W1C): sticky edge flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 4 MASKSET (WO): `irqmask <= irqmask | writedata`.
  - 5 MASKCLR (WO): `irqmask <= irqmask & ~writedata`.
- Strobes:
  - `wr_strobe = chipselect & ~write_n`.
  - `rd_strobe = chipselect & ~read_n`.
- Synchronizer: two flops `sync1 -> sync2`, plus history flop `prev` fed from `sync2`. All three reset to `RESET_VALUE`.
- Edge detect, per bit:
  - rising: `sync2 & ~prev`
  - falling: `~sync2 & prev`
  - any: `sync2 ^ prev`
- EDGECAPTURE bit is set on a detected edge.
- If a detected edge and a W1C clear hit the same bit in the same cycle, set wins and the bit stays 1.
- `irq = |(edgecapture & irqmask)`. It is a combinational OR of registered state, so it is glitch-free.
- `irq` stays high until the host clears the capture bit or the mask bit.
- `readdata` is loaded on the clock edge where `rd_strobe` is high, from the addressed register, zero-extended to 32 bits.
  - When `rd_strobe` is low, `readdata` holds its previous value.
  - Reads have no side effects; reading EDGECAPTURE does not clear it.
- Width rule: only `writedata[DATA_WIDTH-1:0]` is used. Upper bits are ignored.

## Timing
- Reset values:
  - `readdata` = 0, `irq` = 0, `irqmask` = 0, `edgecapture` = 0.
  - `sync1`, `sync2`, `prev` = `RESET_VALUE`.
  - Consequently, no edge is detected out of reset.
- Input latency, for an `in_port` change settled before rising edge N:
  - `sync1` updates at N.
  - `sync2` updates at N+1; DATA reflects the new value from N+1.
  - `edgecapture` sets at N+2; `irq` is high after N+2 if the bit is masked in.
- Read latency: `readdata` is valid in the cycle after the `rd_strobe` cycle. There are no wait states.
- Write latency: register updates at the clock edge of the `wr_strobe` cycle.
  - `irq` reflects a mask or clear write in the following cycle.
- A read and a write in the same cycle cannot occur (`read_n`/`write_n` are exclusive). The slave need not define behaviour for that case.
- Input pulses shorter than one `clk` period may be missed. Pulses of two or more cycles are always captured.
- Reset asserted mid-operation clears all state immediately and asynchronously. `irq` drops within the same cycle.
- Back-to-back edges on a bit already set leave it set; no count is kept.

## Test plan
- Reset and DATA readback:
  - Stimulus: `DATA_WIDTH`=4, `RESET_VALUE`=0; hold `in_port`=4'hA after reset deassert.
  - Required: read addr 0 returns 32'h0000000A one cycle after the strobe; `irq` stays 0 (mask 0).
- Rising capture and irq:
  - Stimulus: `EDGE_TYPE`=0; write IRQMASK=4'h1; drive bit0 0->1 before edge N.
  - Required: `edgecapture`=1 at N+2; `irq`=1 after N+2; read addr 3 returns 1.
- W1C versus simultaneous edge:
  - Stimulus: write addr 3 = 1 in the same cycle a new rising edge is detected on bit0.
  - Required: bit0 remains 1.
  - Then write 1 with no edge: bit0 becomes 0 and `irq` drops the next cycle.
- Mask set/clear aliasing:
  - Stimulus: write addr 4 = 4'h6, then addr 5 = 4'h2.
  - Required: addr 2 reads 4'h4.
  - Write addr 3 = 4'h0: `edgecapture` unchanged.
- Edge type variants:
  - Stimulus: `EDGE_TYPE`=1 and `EDGE_TYPE`=2; toggle bit1 0->1->0 with 3-cycle pulses.
  - Required: falling mode captures only on 1->0; any mode captures on both; 1-cycle glitch checked as not required.
- Reset mid-operation:
  - Stimulus: with `irq`=1 and `edgecapture`=4'hF, assert `reset` between clock edges.
  - Required: `irq`, `readdata`, `irqmask` and `edgecapture` are 0 immediately.
  - After release with `in_port` static, no capture occurs.

Source files
------------

// File: rtl/mysystem_done_signal_in.sv
// Avalon-MM input port returning accelerator done/status to the host:
// two-flop synchronizer, sticky edge capture (W1C) and a maskable level interrupt.
module mysystem_done_signal_in #(
   parameter int unsigned           DATA_WIDTH  = 1,
   parameter int unsigned           EDGE_TYPE   = 0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  read_n,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] sync1;
   logic [DATA_WIDTH-1:0] sync2;
   logic [DATA_WIDTH-1:0] prev;
   logic [DATA_WIDTH-1:0] irqmask;
   logic [DATA_WIDTH-1:0] edgecapture;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] clr_bits;
   logic [31:0]           rd_val;
   logic                  wr_strobe;
   logic                  rd_strobe;

   assign wr_strobe = chipselect & ~write_n;
   assign rd_strobe = chipselect & ~read_n;
   assign wdata     = writedata[DATA_WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= RESET_VALUE;
         sync2 <= RESET_VALUE;
         prev  <= RESET_VALUE;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_comb begin
      if (EDGE_TYPE == 0)
         edge_det = sync2 & ~prev;
      else if (EDGE_TYPE == 1)
         edge_det = ~sync2 & prev;
      else
         edge_det = sync2 ^ prev;
   end

   assign clr_bits = (wr_strobe && address == 3'd3) ? wdata : '0;

   // A new edge overrides a simultaneous W1C on the same bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         edgecapture <= '0;
      else
         edgecapture <= (edgecapture & ~clr_bits) | edge_det;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         irqmask <= '0;
      else if (wr_strobe) begin
         case (address)
            3'd2:    irqmask <= wdata;
            3'd4:    irqmask <= irqmask | wdata;
            3'd5:    irqmask <= irqmask & ~wdata;
            default: irqmask <= irqmask;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         3'd0:    rd_val[DATA_WIDTH-1:0] = sync2;
         3'd2:    rd_val[DATA_WIDTH-1:0] = irqmask;
         3'd3:    rd_val[DATA_WIDTH-1:0] = edgecapture;
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata <= '0;
      else if (rd_strobe)
         readdata <= rd_val;
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_mysystem_done_signal_in.sv
// Directed bench: three instances (rising, falling, any edge) share one bus and in_port.
module tb_mysystem_done_signal_in;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd_r, rd_f, rd_a;
   logic        irq_r, irq_f, irq_a;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mysystem_done_signal_in #(.DATA_WIDTH(4), .EDGE_TYPE(0), .RESET_VALUE(4'h0)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(rd_r), .in_port(in_port), .irq(irq_r));

   mysystem_done_signal_in #(.DATA_WIDTH(4), .EDGE_TYPE(1), .RESET_VALUE(4'h0)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(rd_f), .in_port(in_port), .irq(irq_f));

   mysystem_done_signal_in #(.DATA_WIDTH(4), .EDGE_TYPE(2), .RESET_VALUE(4'h0)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(rd_a), .in_port(in_port), .irq(irq_a));

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic bus_read(input logic [2:0] a,
                           output logic [31:0] r, output logic [31:0] f, output logic [31:0] y);
      @(negedge clk);
      chipselect = 1'b1; read_n = 1'b0; address = a;
      @(posedge clk);
      #1;
      r = rd_r; f = rd_f; y = rd_a;
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] r, f, y;
      reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      address = '0; writedata = '0; in_port = 4'h0;
      wait_neg(2);
      n_checks++;
      if (rd_r !== 32'h0 || rd_f !== 32'h0 || rd_a !== 32'h0 || {irq_r, irq_f, irq_a} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_state: readdata %h/%h/%h irq %b%b%b, required 0", rd_r, rd_f, rd_a, irq_r, irq_f, irq_a);
      end
      reset = 1'b0;
      in_port = 4'hA;
      wait_neg(4);
      bus_read(3'd0, r, f, y);
      n_checks++;
      if (r !== 32'h0000000A || f !== 32'h0000000A || y !== 32'h0000000A) begin
         n_fail++;
         $display("FAIL data_read: got %h/%h/%h, required 0000000a", r, f, y);
      end
      n_checks++;
      if ({irq_r, irq_f, irq_a} !== 3'b000) begin
         n_fail++;
         $display("FAIL irq_mask0: got %b%b%b, required 000", irq_r, irq_f, irq_a);
      end
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'hA || f !== 32'h0 || y !== 32'hA) begin
         n_fail++;
         $display("FAIL capture_after_reset: got %h/%h/%h, required a/0/a", r, f, y);
      end
      bus_write(3'd3, 32'hF);
   endtask

   task automatic test_rising_capture;
      logic [31:0] r, f, y;
      bus_write(3'd2, 32'h1);
      @(negedge clk);
      in_port = 4'hB;
      @(posedge clk);
      @(posedge clk); #1;
      n_checks++;
      if (irq_r !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_early: got %b at N+1, required 0", irq_r);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({irq_r, irq_f, irq_a} !== 3'b101) begin
         n_fail++;
         $display("FAIL irq_rise: got %b%b%b at N+2, required 101", irq_r, irq_f, irq_a);
      end
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h1 || f !== 32'h0 || y !== 32'h1) begin
         n_fail++;
         $display("FAIL capture_rise: got %h/%h/%h, required 1/0/1", r, f, y);
      end
   endtask

   task automatic test_w1c_vs_edge;
      logic [31:0] r, f, y;
      @(negedge clk);
      in_port = 4'hA;
      wait_neg(4);
      in_port = 4'hB;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h1;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h1 || f !== 32'h0 || y !== 32'h1) begin
         n_fail++;
         $display("FAIL w1c_set_wins: got %h/%h/%h, required 1/0/1", r, f, y);
      end
      n_checks++;
      if (irq_r !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_hold: got %b, required 1", irq_r);
      end
      bus_write(3'd3, 32'h1);
      n_checks++;
      if (irq_r !== 1'b0 || irq_a !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_after_clear: got %b/%b, required 0/0", irq_r, irq_a);
      end
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h0 || y !== 32'h0) begin
         n_fail++;
         $display("FAIL w1c_clear: got %h/%h, required 0/0", r, y);
      end
   endtask

   task automatic test_mask_alias;
      logic [31:0] r, f, y;
      bus_write(3'd2, 32'h0);
      bus_write(3'd4, 32'h6);
      bus_write(3'd5, 32'h2);
      bus_read(3'd2, r, f, y);
      n_checks++;
      if (r !== 32'h4 || f !== 32'h4 || y !== 32'h4) begin
         n_fail++;
         $display("FAIL mask_alias: got %h/%h/%h, required 4", r, f, y);
      end
      in_port = 4'hA;
      wait_neg(4);
      bus_write(3'd3, 32'hF);
      in_port = 4'h5;
      wait_neg(4);
      bus_write(3'd3, 32'h0);
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h5 || f !== 32'hA || y !== 32'hF) begin
         n_fail++;
         $display("FAIL w1c_zero: got %h/%h/%h, required 5/a/f", r, f, y);
      end
      n_checks++;
      if ({irq_r, irq_f, irq_a} !== 3'b101) begin
         n_fail++;
         $display("FAIL irq_masked: got %b%b%b, required 101", irq_r, irq_f, irq_a);
      end
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd1, r, f, y);
      n_checks++;
      if (r !== 32'h0 || f !== 32'h0 || y !== 32'h0) begin
         n_fail++;
         $display("FAIL unused_addr: got %h/%h/%h, required 0", r, f, y);
      end
   endtask

   task automatic test_edge_types;
      logic [31:0] r, f, y;
      in_port = 4'h0;
      wait_neg(4);
      bus_write(3'd3, 32'hF);
      in_port = 4'h2;
      wait_neg(3);
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h2 || f !== 32'h0 || y !== 32'h2) begin
         n_fail++;
         $display("FAIL edge_rise_pulse: got %h/%h/%h, required 2/0/2", r, f, y);
      end
      bus_write(3'd3, 32'hF);
      in_port = 4'h0;
      wait_neg(3);
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h0 || f !== 32'h2 || y !== 32'h2) begin
         n_fail++;
         $display("FAIL edge_fall_pulse: got %h/%h/%h, required 0/2/2", r, f, y);
      end
   endtask

   task automatic test_reset_mid_op;
      logic [31:0] r, f, y;
      bus_write(3'd2, 32'hF);
      in_port = 4'hF;
      wait_neg(4);
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'hF || y !== 32'hF || {irq_r, irq_a} !== 2'b11) begin
         n_fail++;
         $display("FAIL pre_reset: got %h/%h irq %b%b, required f/f 11", r, y, irq_r, irq_a);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({irq_r, irq_f, irq_a} !== 3'b000 || rd_r !== 32'h0 || rd_f !== 32'h0 || rd_a !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: irq %b%b%b readdata %h/%h/%h, required 0", irq_r, irq_f, irq_a, rd_r, rd_f, rd_a);
      end
      in_port = 4'h0;
      @(negedge clk);
      reset = 1'b0;
      wait_neg(4);
      bus_read(3'd3, r, f, y);
      n_checks++;
      if (r !== 32'h0 || f !== 32'h0 || y !== 32'h0) begin
         n_fail++;
         $display("FAIL capture_post_reset: got %h/%h/%h, required 0", r, f, y);
      end
      bus_read(3'd2, r, f, y);
      n_checks++;
      if (r !== 32'h0 || f !== 32'h0 || y !== 32'h0 || {irq_r, irq_f, irq_a} !== 3'b000) begin
         n_fail++;
         $display("FAIL mask_post_reset: got %h/%h/%h irq %b%b%b, required 0", r, f, y, irq_r, irq_f, irq_a);
      end
   endtask

   initial begin
      test_reset;
      test_rising_capture;
      test_w1c_vs_edge;
      test_mask_alias;
      test_edge_types;
      test_reset_mid_op;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
